// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch unit.
package fetch_pkg;
  localparam int FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {RUN, DRAIN} fetch_state_e;
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
    logic                  misalign;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with wrap-bit pointers, simultaneous push/pop and a synchronous clear.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic w_push, w_pop;
  assign count = r_wptr - r_rptr;
  assign empty = r_wptr == r_rptr;
  assign full = count[AW];
  assign w_pop = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout = r_mem[r_rptr[AW-1:0]];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: in-order imem fetch with tag queue, output FIFO, misalign side slot and flush drain.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN = FETCH_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_addr,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_misalign
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);
  localparam int AW = $clog2(DEPTH);
  fetch_state_e r_state, w_state_nx;
  fetch_entry_t r_slot, w_fin, w_head;
  logic [AW:0] r_out, r_drop, w_tcnt, w_fcnt, w_inflight;
  logic [XLEN-1:0] w_tag;
  logic r_slot_v, w_issue, w_fire, w_rsp, w_mis, w_mis_take, w_slot_push, w_fpush;
  logic w_tfull, w_tempty, w_ffull, w_fempty, w_pop;
  assign w_mis = pc_addr[1:0] != 2'b00;
  assign w_rsp = imem_rsp_valid && r_out != '0;
  assign w_inflight = r_out - {{AW{1'b0}}, w_rsp};
  assign w_fire = imem_req_valid && imem_req_ready;
  assign w_mis_take = pc_valid && pc_ready && w_mis;
  assign w_slot_push = r_slot_v && r_out == '0 && !flush;
  assign w_fpush = (w_rsp && r_state == RUN && !flush) || w_slot_push;
  assign w_fin = w_slot_push ? r_slot : '{pc: w_tag, instr: imem_rsp_data, misalign: 1'b0};
  assign w_pop = if_valid && if_ready;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RUN;
    else r_state <= w_state_nx;
  end
  always_comb begin
    w_state_nx = r_state == RUN ? ((flush && w_inflight != '0) ? DRAIN : RUN)
                                : ((w_rsp && r_drop == (AW+1)'(1)) ? RUN : DRAIN);
  end
  always_comb begin
    w_issue = reset && r_state == RUN && !flush && !r_slot_v &&
              (({1'b0, r_out} + {1'b0, w_fcnt}) < (AW+2)'(DEPTH));
    pc_ready = w_issue && imem_req_ready;
    imem_req_valid = w_issue && pc_valid && !w_mis;
    imem_req_addr = reset ? {pc_addr[XLEN-1:2], 2'b00} : '0;
  end
  // drop_cnt tracks in-flight words owed to a flushed stream; it mirrors r_out while draining
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out <= '0;
      r_drop <= '0;
      r_slot_v <= 1'b0;
      r_slot <= '0;
    end else begin
      r_out <= r_out + {{AW{1'b0}}, w_fire} - {{AW{1'b0}}, w_rsp};
      r_drop <= r_state == RUN ? (flush ? w_inflight : '0) : r_drop - {{AW{1'b0}}, w_rsp};
      r_slot_v <= (flush || w_slot_push) ? 1'b0 : (r_slot_v || w_mis_take);
      if (w_mis_take) r_slot <= '{pc: pc_addr, instr: NOP_INSTR, misalign: 1'b1};
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .W(XLEN)) u_tagq (
    .clk(clk), .reset(reset), .clr(flush), .push(w_fire), .din(pc_addr),
    .pop(w_rsp && r_state == RUN), .dout(w_tag), .full(w_tfull), .empty(w_tempty), .count(w_tcnt)
  );
  fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_outq (
    .clk(clk), .reset(reset), .clr(flush), .push(w_fpush), .din(w_fin),
    .pop(w_pop), .dout(w_head), .full(w_ffull), .empty(w_fempty), .count(w_fcnt)
  );
  assign if_valid = !w_fempty;
  assign if_pc = if_valid ? w_head.pc : '0;
  assign if_instr = if_valid ? w_head.instr : '0;
  assign if_misalign = if_valid && w_head.misalign;
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      if (w_pop) perf_fetched <= perf_fetched + 32'd1;
      if (pc_valid && !pc_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
  a_rsp_orphan: assert property (@(posedge clk) disable iff (!reset) !(imem_rsp_valid && r_out == '0));
  a_tag_track: assert property (@(posedge clk) disable iff (!reset) (r_state == RUN) |-> (w_tcnt == r_out));
  a_tag_nonempty: assert property (@(posedge clk) disable iff (!reset) !(w_rsp && r_state == RUN && w_tempty));
  a_tag_room: assert property (@(posedge clk) disable iff (!reset) !(w_fire && w_tfull));
  a_fifo_room: assert property (@(posedge clk) disable iff (!reset) !(w_fpush && w_ffull && !w_pop));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed tests for instr_fetch_unit with an in-order fixed-latency memory model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] pc_addr = '0, imem_req_addr, imem_rsp_data = '0, if_pc, if_instr;
  logic pc_valid = 1'b0, pc_ready, flush = 1'b0, imem_req_valid, imem_req_ready = 1'b1;
  logic imem_rsp_valid = 1'b0, if_valid, if_ready = 1'b1, if_misalign;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif
  int checks = 0, errors = 0, cyc = 0, lat = 1;
  logic [31:0] pcq[$], req_log[$], pend_a[$], dpc[$], dins[$];
  logic dmis[$];
  int pend_t[$];

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .if_misalign(if_misalign)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic drive();
    imem_rsp_valid = pend_t.size() > 0 && pend_t[0] <= cyc;
    imem_rsp_data = imem_rsp_valid ? mem_word(pend_a[0]) : '0;
    pc_valid = pcq.size() > 0;
    pc_addr = pc_valid ? pcq[0] : '0;
  endtask

  task automatic advance();
    if (imem_rsp_valid) begin
      void'(pend_a.pop_front());
      void'(pend_t.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      req_log.push_back(imem_req_addr);
      pend_a.push_back(imem_req_addr);
      pend_t.push_back(cyc + lat);
    end
    if (pc_valid && pc_ready) void'(pcq.pop_front());
    if (if_valid && if_ready) begin
      dpc.push_back(if_pc);
      dins.push_back(if_instr);
      dmis.push_back(if_misalign);
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic tick();
    @(negedge clk);
    advance();
  endtask

  task automatic clear_logs();
    req_log.delete();
    dpc.delete();
    dins.delete();
    dmis.delete();
  endtask

  task automatic test_reset();
    lat = 1;
    pcq.push_back(32'h0);
    drive();
    repeat (3) tick();
    checks++; if (req_log.size() != 0) begin errors++; $display("FAIL reset_no_req: got %0d requests, expected 0", req_log.size()); end
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL reset_pc_ready: got %b expected 0", pc_ready); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
    advance();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h expected 00000000", imem_req_addr); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL first_pc_ready: got %b expected 1", pc_ready); end
    advance();
    repeat (4) tick();
    checks++; if (dpc.size() != 1 || dins[0] !== 32'hC0DE0000) begin errors++; $display("FAIL first_word: got %0d words instr %h, expected 1 word C0DE0000", dpc.size(), dins[0]); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc[3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] exp_in[3] = '{32'hC0DE0000, 32'hC0DE0004, 32'hC0DE0008};
    int first;
    clear_logs();
    lat = 1;
    if_ready = 1'b1;
    pcq = '{32'h0, 32'h4, 32'h8};
    drive();
    first = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_valid && first < 0) first = i;
      if (first >= 0 && i - first < 3) begin
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_gap: cycle %0d if_valid=%b expected 1", i, if_valid); end
      end
      advance();
    end
    checks++; if (dpc.size() != 3) begin errors++; $display("FAIL stream_count: got %0d expected 3", dpc.size()); end
    for (int i = 0; i < 3 && i < dpc.size(); i++) begin
      checks++; if (dpc[i] !== exp_pc[i] || dins[i] !== exp_in[i] || dmis[i] !== 1'b0) begin
        errors++; $display("FAIL stream_word%0d: got %h/%h/%b expected %h/%h/0", i, dpc[i], dins[i], dmis[i], exp_pc[i], exp_in[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc[6] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24};
    clear_logs();
    lat = 1;
    if_ready = 1'b0;
    pcq = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24};
    drive();
    repeat (8) tick();
    checks++; if (req_log.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", req_log.size()); end
    @(negedge clk);
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", pc_ready); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10) begin errors++; $display("FAIL bp_head: got %b/%h expected 1/00000010", if_valid, if_pc); end
    advance();
    @(negedge clk);
    checks++; if (if_pc !== 32'h10 || if_instr !== 32'hC0DE0010) begin errors++; $display("FAIL bp_head_stable: got %h/%h expected 00000010/C0DE0010", if_pc, if_instr); end
    advance();
    if_ready = 1'b1;
    @(negedge clk);
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_ready: got %b expected 0", pc_ready); end
    advance();
    if_ready = 1'b0;
    @(negedge clk);
    checks++; if (pc_ready !== 1'b1 || imem_req_addr !== 32'h20) begin errors++; $display("FAIL bp_resume: got %b/%h expected 1/00000020", pc_ready, imem_req_addr); end
    advance();
    if_ready = 1'b1;
    repeat (12) tick();
    checks++; if (dpc.size() != 6) begin errors++; $display("FAIL bp_delivered: got %0d expected 6", dpc.size()); end
    for (int i = 0; i < 6 && i < dpc.size(); i++) begin
      checks++; if (dpc[i] !== exp_pc[i]) begin errors++; $display("FAIL bp_order%0d: got %h expected %h", i, dpc[i], exp_pc[i]); end
    end
  endtask

  task automatic test_flush();
    clear_logs();
    lat = 3;
    if_ready = 1'b1;
    pcq = '{32'h40, 32'h44, 32'h48};
    drive();
    repeat (3) tick();
    checks++; if (req_log.size() != 3) begin errors++; $display("FAIL flush_inflight: got %0d expected 3", req_log.size()); end
    flush = 1'b1;
    pcq.push_back(32'h100);
    drive();
    @(negedge clk);
    checks++; if (pc_ready !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle_issue: got %b/%b expected 0/0", pc_ready, imem_req_valid); end
    advance();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (dut.r_state !== DRAIN || dut.r_drop !== 3'd2) begin errors++; $display("FAIL flush_drain: got state %0d drop %0d expected 1/2", dut.r_state, dut.r_drop); end
    checks++; if (pc_ready !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL drain_outputs: got %b/%b expected 0/0", pc_ready, if_valid); end
    advance();
    tick();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL flush_restart: got %b/%h expected 1/00000100", imem_req_valid, imem_req_addr); end
    advance();
    repeat (6) tick();
    checks++; if (dpc.size() != 1 || dpc[0] !== 32'h100 || dins[0] !== 32'hC0DE0100) begin
      errors++; $display("FAIL flush_first_word: got %0d words %h/%h expected 1 word 00000100/C0DE0100", dpc.size(), dpc[0], dins[0]);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc[3] = '{32'h4, 32'h6, 32'h8};
    logic [31:0] exp_in[3] = '{32'hC0DE0004, 32'h00000013, 32'hC0DE0008};
    logic exp_m[3] = '{1'b0, 1'b1, 1'b0};
    clear_logs();
    lat = 3;
    if_ready = 1'b1;
    pcq = '{32'h4, 32'h6, 32'h8};
    drive();
    tick();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0 || pc_ready !== 1'b1) begin errors++; $display("FAIL mis_accept: got req %b ready %b expected 0/1", imem_req_valid, pc_ready); end
    advance();
    @(negedge clk);
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL mis_slot_ready: got %b expected 0", pc_ready); end
    advance();
    repeat (12) tick();
    checks++; if (req_log.size() != 2 || req_log[0] !== 32'h4 || req_log[1] !== 32'h8) begin
      errors++; $display("FAIL mis_requests: got %0d reqs %h %h expected 2 reqs 00000004 00000008", req_log.size(), req_log[0], req_log[1]);
    end
    checks++; if (dpc.size() != 3) begin errors++; $display("FAIL mis_count: got %0d expected 3", dpc.size()); end
    for (int i = 0; i < 3 && i < dpc.size(); i++) begin
      checks++; if (dpc[i] !== exp_pc[i] || dins[i] !== exp_in[i] || dmis[i] !== exp_m[i]) begin
        errors++; $display("FAIL mis_word%0d: got %h/%h/%b expected %h/%h/%b", i, dpc[i], dins[i], dmis[i], exp_pc[i], exp_in[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_reset_midop();
    clear_logs();
    lat = 1;
    if_ready = 1'b0;
    pcq = '{32'h200, 32'h204};
    drive();
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || dut.r_out !== 3'd0) begin errors++; $display("FAIL async_reset: got if_valid %b out %0d expected 0/0", if_valid, dut.r_out); end
    pcq.delete();
    pend_a.delete();
    pend_t.delete();
    drive();
    repeat (2) tick();
    reset = 1'b1;
    if_ready = 1'b1;
    @(negedge clk);
    checks++; if (pc_ready !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL post_reset: got ready %b if_valid %b expected 1/0", pc_ready, if_valid); end
    advance();
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    reset = 1'b0;
    pcq.delete();
    pend_a.delete();
    pend_t.delete();
    drive();
    repeat (2) tick();
    reset = 1'b1;
    lat = 1;
    if_ready = 1'b1;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 10; i++) pcq.push_back(32'h300 + 32'(4 * i));
    drive();
    repeat (3) tick();
    imem_req_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    checks++; if (perf_fetched !== 32'd10) begin errors++; $display("FAIL perf_fetched: got %0d expected 10", perf_fetched); end
    checks++; if (perf_stall !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d expected 3", perf_stall); end
    advance();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_misalign();
    test_reset_midop();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
